// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the dual-clock Gray-pointer FIFO.
// Used by both the write-side full/level block and the read-side empty block.
package fifo_ptr_pkg;

  localparam int MAX_ADDRSIZE = 16;

  function automatic logic [16:0] bin2gray(input logic [16:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix XOR from the MSB down; callers zero-extend narrower pointers.
  function automatic logic [16:0] gray2bin(input logic [16:0] g);
    logic [16:0] b;
    b[16] = g[16];
    for (int i = 15; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wptr_full_lvl_if.sv
// Write-side FIFO pointer bus: request/threshold in, flags/pointers/level out.
interface wptr_full_lvl_if #(
  parameter int ADDRSIZE = 4
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   afull_thresh;
  logic                wovf_clr;
  logic                wfull;
  logic                awfull;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;

  modport master (
    output winc, wq2_rptr, afull_thresh, wovf_clr,
    input  wfull, awfull, waddr, wptr, wlevel, wovf
  );

  modport slave (
    input  winc, wq2_rptr, afull_thresh, wovf_clr,
    output wfull, awfull, waddr, wptr, wlevel, wovf
  );
endinterface

// File: rtl/wptr_full_lvl.sv
// Write pointer, full / almost-full flags, occupancy level and sticky
// overflow for the write domain of a Gray-pointer dual-clock FIFO.
module wptr_full_lvl
  import fifo_ptr_pkg::*;
#(
  parameter int ADDRSIZE = 4
) (
  input  logic            wclk,
  input  logic            wrst_n,
  wptr_full_lvl_if.slave  bus
);

  localparam int FW = MAX_ADDRSIZE + 1;

  typedef logic [ADDRSIZE:0] ptr_t;

  ptr_t wbin;
  ptr_t wptr_q;
  ptr_t wlevel_q;
  logic wfull_q;
  logic awfull_q;
  logic wovf_q;

  ptr_t wbinnext;
  ptr_t wgraynext;
  ptr_t rbin_s;
  ptr_t lvl_next;
  logic wr_en;
  logic wfull_val;
  logic awfull_val;

  always_comb begin
    wr_en      = bus.winc & ~wfull_q;
    wbinnext   = wbin + ptr_t'(wr_en);
    wgraynext  = ptr_t'(bin2gray(FW'(wbinnext)));
    rbin_s     = ptr_t'(gray2bin(FW'(bus.wq2_rptr)));
    // Read pointer lags by the synchroniser, so this never under-reports.
    lvl_next   = wbinnext - rbin_s;
    // Full: top two Gray bits inverted, remaining bits equal.
    wfull_val  = (wgraynext == {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1],
                                bus.wq2_rptr[ADDRSIZE-2:0]});
    awfull_val = (lvl_next >= bus.afull_thresh);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin     <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      awfull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin     <= wbinnext;
      wptr_q   <= wgraynext;
      wlevel_q <= lvl_next;
      wfull_q  <= wfull_val;
      awfull_q <= awfull_val;
      // A blocked write takes priority over a clear in the same cycle.
      if (bus.winc && wfull_q)
        wovf_q <= 1'b1;
      else if (bus.wovf_clr)
        wovf_q <= 1'b0;
    end
  end

  assign bus.waddr  = wbin[ADDRSIZE-1:0];
  assign bus.wptr   = wptr_q;
  assign bus.wlevel = wlevel_q;
  assign bus.wfull  = wfull_q;
  assign bus.awfull = awfull_q;
  assign bus.wovf   = wovf_q;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Directed bench for wptr_full_lvl with ADDRSIZE=4: vector table for fill,
// overflow and release, plus sequences for lagged reads, reset and thresholds.
module tb_wptr_full_lvl;

  localparam int AW = 4;

  logic wclk;
  logic wrst_n;

  wptr_full_lvl_if #(.ADDRSIZE(AW)) bus ();

  wptr_full_lvl #(.ADDRSIZE(AW)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  typedef struct {
    logic       winc;
    logic       clr;
    logic [4:0] wq2;
    logic [4:0] thr;
    logic       e_full;
    logic       e_afull;
    logic [3:0] e_waddr;
    logic [4:0] e_wptr;
    logic [4:0] e_lvl;
    logic       e_ovf;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t vt[25];

  function automatic vec_t mk(logic winc, logic clr, logic [4:0] wq2, logic [4:0] thr,
                              logic f, logic af, logic [3:0] wa, logic [4:0] wp,
                              logic [4:0] lv, logic ov);
    vec_t v;
    v.winc = winc; v.clr = clr; v.wq2 = wq2; v.thr = thr;
    v.e_full = f; v.e_afull = af; v.e_waddr = wa; v.e_wptr = wp;
    v.e_lvl = lv; v.e_ovf = ov;
    return v;
  endfunction

  function automatic logic [4:0] g5(int b);
    logic [4:0] x;
    x = 5'(b);
    return (x >> 1) ^ x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    wrst_n           = 1'b0;
    bus.winc         = 1'b0;
    bus.wovf_clr     = 1'b0;
    bus.wq2_rptr     = '0;
    bus.afull_thresh = 5'd12;
    #3;
    chk("reset_outputs",
        {bus.wfull, bus.awfull, bus.waddr, bus.wptr, bus.wlevel, bus.wovf}, 32'd0);
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    // Fill: 16 writes with read pointer at 0, threshold 12.
    vt[0]  = mk(1,0,5'b00000,12, 0,0, 1,5'b00001, 1,0);
    vt[1]  = mk(1,0,5'b00000,12, 0,0, 2,5'b00011, 2,0);
    vt[2]  = mk(1,0,5'b00000,12, 0,0, 3,5'b00010, 3,0);
    vt[3]  = mk(1,0,5'b00000,12, 0,0, 4,5'b00110, 4,0);
    vt[4]  = mk(1,0,5'b00000,12, 0,0, 5,5'b00111, 5,0);
    vt[5]  = mk(1,0,5'b00000,12, 0,0, 6,5'b00101, 6,0);
    vt[6]  = mk(1,0,5'b00000,12, 0,0, 7,5'b00100, 7,0);
    vt[7]  = mk(1,0,5'b00000,12, 0,0, 8,5'b01100, 8,0);
    vt[8]  = mk(1,0,5'b00000,12, 0,0, 9,5'b01101, 9,0);
    vt[9]  = mk(1,0,5'b00000,12, 0,0,10,5'b01111,10,0);
    vt[10] = mk(1,0,5'b00000,12, 0,0,11,5'b01110,11,0);
    vt[11] = mk(1,0,5'b00000,12, 0,1,12,5'b01010,12,0);
    vt[12] = mk(1,0,5'b00000,12, 0,1,13,5'b01011,13,0);
    vt[13] = mk(1,0,5'b00000,12, 0,1,14,5'b01001,14,0);
    vt[14] = mk(1,0,5'b00000,12, 0,1,15,5'b01000,15,0);
    vt[15] = mk(1,0,5'b00000,12, 1,1, 0,5'b11000,16,0);
    // Writes while full: pointers hold, overflow sticks.
    vt[16] = mk(1,0,5'b00000,12, 1,1, 0,5'b11000,16,1);
    vt[17] = mk(1,0,5'b00000,12, 1,1, 0,5'b11000,16,1);
    vt[18] = mk(1,0,5'b00000,12, 1,1, 0,5'b11000,16,1);
    vt[19] = mk(0,1,5'b00000,12, 1,1, 0,5'b11000,16,0);
    vt[20] = mk(1,1,5'b00000,12, 1,1, 0,5'b11000,16,1);
    vt[21] = mk(0,1,5'b00000,12, 1,1, 0,5'b11000,16,0);
    // One read becomes visible: full drops, next write refills across the wrap.
    vt[22] = mk(0,0,5'b00001,12, 0,1, 0,5'b11000,15,0);
    vt[23] = mk(1,0,5'b00001,12, 1,1, 1,5'b11001,16,0);
    vt[24] = mk(1,0,5'b00001,12, 1,1, 1,5'b11001,16,1);

    do_reset();

    for (int i = 0; i < 25; i++) begin
      bus.winc         = vt[i].winc;
      bus.wovf_clr     = vt[i].clr;
      bus.wq2_rptr     = vt[i].wq2;
      bus.afull_thresh = vt[i].thr;
      @(negedge wclk);
      chk($sformatf("vec%0d {full,afull,waddr,wptr,lvl,ovf}", i),
          {bus.wfull, bus.awfull, bus.waddr, bus.wptr, bus.wlevel, bus.wovf},
          {vt[i].e_full, vt[i].e_afull, vt[i].e_waddr, vt[i].e_wptr,
           vt[i].e_lvl, vt[i].e_ovf});
    end

    // Interleaved writes and reads with a 2-cycle visible-pointer lag.
    do_reset();
    begin
      int wcount = 0, rcount = 0, rd1 = 0, rd2 = 0, seen = 0;
      for (int cyc = 0; cyc < 140; cyc++) begin
        int exp_lvl;
        logic acc;
        exp_lvl = wcount - seen;
        if (cyc > 0) begin
          chk($sformatf("lag_lvl c%0d", cyc), 32'(bus.wlevel), 32'(exp_lvl));
          chk($sformatf("lag_full c%0d", cyc), 32'(bus.wfull), 32'(exp_lvl == 16));
          if (int'(bus.wlevel) < wcount - rcount || bus.wlevel > 5'd16) begin
            n_err++;
            $display("FAIL lag_bound c%0d: level %0d, true occupancy %0d",
                     cyc, bus.wlevel, wcount - rcount);
          end
        end
        bus.winc = (cyc % 5) != 4;
        acc = bus.winc & ~bus.wfull;
        if ((cyc % 3) != 0 && rcount < wcount) rcount++;
        if (acc) wcount++;
        bus.wq2_rptr = g5(rd2);
        seen = rd2;
        rd2  = rd1;
        rd1  = rcount;
        @(negedge wclk);
      end
      chk("lag_wrapped_twice", 32'(wcount > 64), 32'd1);
    end

    // Asynchronous reset in the middle of a burst at level 9.
    do_reset();
    bus.winc = 1'b1;
    repeat (9) @(negedge wclk);
    chk("pre_rst_lvl", 32'(bus.wlevel), 32'd9);
    #2 wrst_n = 1'b0;
    #1;
    chk("async_rst_outputs",
        {bus.wfull, bus.awfull, bus.waddr, bus.wptr, bus.wlevel, bus.wovf}, 32'd0);
    bus.winc = 1'b0;
    @(negedge wclk);
    wrst_n = 1'b1;
    bus.winc = 1'b1;
    #1 chk("post_rst_waddr", 32'(bus.waddr), 32'd0);
    @(negedge wclk);
    chk("post_rst_write", {bus.waddr, bus.wlevel}, {4'd1, 5'd1});
    bus.winc = 1'b0;

    // Threshold 0: almost-full from the first edge.
    do_reset();
    bus.afull_thresh = 5'd0;
    @(negedge wclk);
    chk("thr0_afull", 32'(bus.awfull), 32'd1);

    // Threshold 17: never asserted, even when full.
    do_reset();
    bus.afull_thresh = 5'd17;
    bus.winc = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      @(negedge wclk);
      chk($sformatf("thr17_afull w%0d", i), 32'(bus.awfull), 32'd0);
    end
    chk("thr17_full", 32'(bus.wfull), 32'd1);
    bus.winc = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
